cq_viola_led_seq: RTL and testbench

CQ_VIOLA_LED_SEQ -- requirements
Module: cq_viola_led_seq

---
 rtl/cq_viola_led_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_cq_viola_led_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cq_viola_led_seq.sv
`default_nettype none
// ============================================================================
// Module   : cq_viola_led_seq
// Brief    : CSR-programmed LED pattern sequencer. Walks a 32-bit PATTERN
//            LSB first, issuing one single-bit write per step to an LED PIO
//            slave through a simple master port, with a programmable tick
//            period between writes and optional one-shot operation.
// Option   : define LEDSEQ_IRQ_EN to add the IRQEN control bit, the irq
//            output and write-1-to-clear of STATUS.DONE.
// Revision : 1.0 - initial release
// ============================================================================
module cq_viola_led_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
`ifdef LEDSEQ_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
  localparam logic [1:0] c_ADDR_PERIOD = 2'd1;
  localparam logic [1:0] c_ADDR_PATTERN = 2'd2;
  localparam logic [1:0] c_ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_run;
  logic        r_oneshot;
  logic [4:0]  r_len;
  logic [31:0] r_period;
  logic [31:0] r_pattern;
  logic        r_done;
  logic [4:0]  r_idx;
  logic [31:0] r_cnt;
  logic        r_wbit;

  logic        w_csr_wr;
  logic        w_wr_ctrl;
  logic        w_wr_period;
  logic        w_wr_pattern;
  logic        w_wr_status;
  logic        w_start;
  logic        w_last;
  logic        w_xfer_done;
  logic        w_finish;
  logic        w_load_cnt;
  logic        w_dec_cnt;
  logic        w_issue;
  logic        w_done_nxt;
  logic        w_irqen;
  logic        w_busy;

  // CSR write decode; a start is RUN being written 1 while currently 0
  always_comb begin
    w_csr_wr     = chipselect & ~write_n;
    w_wr_ctrl    = w_csr_wr & (address == c_ADDR_CTRL);
    w_wr_period  = w_csr_wr & (address == c_ADDR_PERIOD);
    w_wr_pattern = w_csr_wr & (address == c_ADDR_PATTERN);
    w_wr_status  = w_csr_wr & (address == c_ADDR_STATUS);
    w_start      = w_wr_ctrl & writedata[0] & ~r_run;
    // >= rather than == so a LEN lowered below IDX still wraps
    w_last       = (r_idx >= r_len);
    w_busy       = (r_state != S_IDLE);
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state, master strobes and datapath control pulses
  always_comb begin
    w_state_nxt  = r_state;
    w_xfer_done  = 1'b0;
    w_finish     = 1'b0;
    w_load_cnt   = 1'b0;
    w_dec_cnt    = 1'b0;
    w_issue      = 1'b0;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_start || r_run) begin
          w_state_nxt = S_WRITE;
          w_issue     = 1'b1;
        end
      end
      S_WRITE: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        if (!m_waitrequest) begin
          w_xfer_done = 1'b1;
          if (w_last && r_oneshot) begin
            w_finish    = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (!r_run) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_load_cnt  = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!r_run) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 32'd0) begin
          w_state_nxt = S_WRITE;
          w_issue     = 1'b1;
        end else begin
          w_dec_cnt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // DONE next value: FSM sets it, CSR-side clears are applied last so they win
  always_comb begin
    w_done_nxt = r_done;
    if (w_finish) w_done_nxt = 1'b1;
    if (w_start)  w_done_nxt = 1'b0;
`ifdef LEDSEQ_IRQ_EN
    if (w_wr_status && writedata[1]) w_done_nxt = 1'b0;
`endif
  end

  // CONTROL, PERIOD, PATTERN and DONE registers; CSR write beats FSM RUN clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run     <= 1'b0;
      r_oneshot <= 1'b0;
      r_len     <= 5'd0;
      r_period  <= 32'd0;
      r_pattern <= 32'd0;
      r_done    <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_run     <= writedata[0];
        r_oneshot <= writedata[1];
        r_len     <= writedata[12:8];
      end else if (w_finish) begin
        r_run <= 1'b0;
      end
      if (w_wr_period)  r_period  <= writedata;
      if (w_wr_pattern) r_pattern <= writedata;
      r_done <= w_done_nxt;
    end
  end

  // Step index, tick counter and the latched bit of the write in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx  <= 5'd0;
      r_cnt  <= 32'd0;
      r_wbit <= 1'b0;
    end else begin
      if (w_start)          r_idx <= 5'd0;
      else if (w_xfer_done) r_idx <= w_last ? 5'd0 : r_idx + 5'd1;
      if (w_load_cnt)       r_cnt <= r_period;
      else if (w_dec_cnt)   r_cnt <= r_cnt - 32'd1;
      // Sampled once on entry to WRITE so mid-write PATTERN updates cannot
      // disturb the data presented during a stall
      if (w_issue)          r_wbit <= r_pattern[w_start ? 5'd0 : r_idx];
    end
  end

`ifdef LEDSEQ_IRQ_EN
  logic r_irqen;
  logic r_irq;

  // IRQEN bit and interrupt register tracking DONE&IRQEN without lag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqen <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_irqen <= writedata[2];
      r_irq <= w_done_nxt & (w_wr_ctrl ? writedata[2] : r_irqen);
    end
  end

  assign w_irqen = r_irqen;
  assign irq     = r_irq;
`else
  assign w_irqen = 1'b0;
`endif

  assign m_address   = 2'd0;
  assign m_writedata = {31'd0, r_wbit};

  // CSR read mux, unused bits zero
  always_comb begin
    readdata = 32'd0;
    case (address)
      c_ADDR_CTRL: begin
        readdata[0]    = r_run;
        readdata[1]    = r_oneshot;
        readdata[2]    = w_irqen;
        readdata[12:8] = r_len;
      end
      c_ADDR_PERIOD:  readdata = r_period;
      c_ADDR_PATTERN: readdata = r_pattern;
      c_ADDR_STATUS: begin
        readdata[0]    = w_busy;
        readdata[1]    = r_done;
        readdata[12:8] = r_idx;
      end
      default: readdata = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cq_viola_led_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cq_viola_led_seq
// Brief    : Self-checking bench for cq_viola_led_seq: directed scenarios plus
//            randomized one-shot runs checked against a pattern/timing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cq_viola_led_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest = 1'b0;
`ifdef LEDSEQ_IRQ_EN
  logic        irq;
`endif

  cq_viola_led_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .m_waitrequest(m_waitrequest)
`ifdef LEDSEQ_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  bit          rand_wait = 1'b0;

  // Observed completed master writes
  bit          q_data[$];
  int unsigned q_time[$];
  int unsigned q_hold[$];
  int unsigned hold_cnt = 0;
  logic [31:0] hold_data = 32'd0;
  bit          unstable = 1'b0;
  bit          addr_bad = 1'b0;

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (m_chipselect && !m_write_n) begin
      if (hold_cnt != 0 && m_writedata !== hold_data) unstable = 1'b1;
      if (m_address !== 2'd0) addr_bad = 1'b1;
      hold_data = m_writedata;
      hold_cnt++;
      if (!m_waitrequest) begin
        if (m_writedata[31:1] !== 31'd0) unstable = 1'b1;
        q_data.push_back(m_writedata[0]);
        q_time.push_back(cyc);
        q_hold.push_back(hold_cnt);
        hold_cnt = 0;
      end
    end else begin
      hold_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_wait) m_waitrequest = ($urandom_range(0, 2) == 0);
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic clr_mon();
    q_data.delete();
    q_time.delete();
    q_hold.delete();
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    logic [31:0] s;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      csr_rd(2'd3, s);
      if (!s[0]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference: k-th written bit of a run cycling over PATTERN[0..LEN]
  function automatic bit exp_bit(input logic [31:0] pat, input int k, input int len);
    return pat[k % (len + 1)];
  endfunction

  initial begin
    logic [31:0] rd;
    int          n0;
    bit          ok;

    repeat (3) @(posedge clk);
    #1;
    // Reset values observed while still in reset
    chk("rst_cs", 32'(m_chipselect), 32'd0);
    chk("rst_wn", 32'(m_write_n), 32'd1);
    chk("rst_wd", m_writedata, 32'd0);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      csr_rd(a[1:0], rd);
      chk($sformatf("rst_csr%0d", a), rd, 32'd0);
      tick();
    end

    // Continuous run: PERIOD=3, PATTERN=5, LEN=3
    csr_wr(2'd1, 32'd3);
    csr_wr(2'd2, 32'h5);
    clr_mon();
    csr_wr(2'd0, 32'h301);
    repeat (32) tick();
    chk("cont_count_ge6", 32'(q_data.size() >= 6), 32'd1);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("cont_bit%0d", k), 32'(q_data[k]), 32'(exp_bit(32'h5, k, 3)));
      if (k > 0) chk($sformatf("cont_gap%0d", k), q_time[k] - q_time[k-1], 32'd5);
    end
    csr_wr(2'd0, 32'h300);
    repeat (8) tick();
    n0 = q_data.size();
    repeat (20) tick();
    chk("cont_stop_nowrites", 32'(q_data.size()), 32'(n0));
    csr_rd(2'd3, rd);
    chk("cont_stop_busy", 32'(rd[0]), 32'd0);

    // Stall of 4 cycles on the first write, PERIOD=10
    csr_wr(2'd1, 32'd10);
    csr_wr(2'd2, 32'h1);
    clr_mon();
    m_waitrequest = 1'b1;
    csr_wr(2'd0, 32'h301);
    repeat (4) tick();
    m_waitrequest = 1'b0;
    repeat (2) tick();
    csr_rd(2'd3, rd);
    chk("stall_status", rd, 32'h101);
    chk("stall_hold", q_hold[0], 32'd5);
    chk("stall_data", 32'(q_data[0]), 32'd1);
    csr_wr(2'd0, 32'h300);
    repeat (15) tick();
    chk("stall_count", 32'(q_data.size()), 32'd1);

    // RUN cleared during the first cycle of a stalled write
    clr_mon();
    m_waitrequest = 1'b1;
    csr_wr(2'd0, 32'h301);
    csr_wr(2'd0, 32'h300);
    repeat (3) tick();
    m_waitrequest = 1'b0;
    repeat (20) tick();
    chk("stop_in_write_count", 32'(q_data.size()), 32'd1);
    csr_rd(2'd3, rd);
    chk("stop_in_write_status", rd, 32'h100);

    // Randomized one-shot runs against the reference model
    for (int it = 0; it < 8; it++) begin
      logic [31:0] pat, len, per;
      bit stall;
      pat   = $urandom;
      len   = 32'($urandom_range(0, 7));
      per   = 32'($urandom_range(0, 3));
      stall = it[0];
      m_waitrequest = 1'b0;
      csr_wr(2'd1, per);
      csr_wr(2'd2, pat);
      clr_mon();
      rand_wait = stall;
      csr_wr(2'd0, (len << 8) | 32'h3);
      wait_idle(600, ok);
      rand_wait     = 1'b0;
      m_waitrequest = 1'b0;
      chk($sformatf("rnd%0d_done_in_time", it), 32'(ok), 32'd1);
      chk($sformatf("rnd%0d_count", it), 32'(q_data.size()), len + 32'd1);
      for (int k = 0; k <= int'(len); k++) begin
        chk($sformatf("rnd%0d_bit%0d", it, k), 32'(q_data[k]), 32'(exp_bit(pat, k, int'(len))));
        if (!stall && k > 0)
          chk($sformatf("rnd%0d_gap%0d", it, k), q_time[k] - q_time[k-1], per + 32'd2);
      end
      csr_rd(2'd3, rd);
      chk($sformatf("rnd%0d_status", it), rd, 32'h2);
      tick();
      csr_rd(2'd0, rd);
      chk($sformatf("rnd%0d_ctrl", it), rd, (len << 8) | 32'h2);
    end

`ifdef LEDSEQ_IRQ_EN
    // Interrupt raised by a finished one-shot, cleared by STATUS write
    csr_wr(2'd1, 32'd0);
    csr_wr(2'd0, 32'h7);
    wait_idle(50, ok);
    tick();
    chk("irq_set", 32'(irq), 32'd1);
    csr_wr(2'd3, 32'h2);
    chk("irq_clr", 32'(irq), 32'd0);
`endif

    // Reset pulsed in the middle of WAIT
    csr_wr(2'd1, 32'd20);
    csr_wr(2'd2, 32'h1);
    clr_mon();
    csr_wr(2'd0, 32'h301);
    repeat (5) tick();
    chk("rwait_first_write", 32'(q_data.size()), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rwait_cs", 32'(m_chipselect), 32'd0);
    chk("rwait_wn", 32'(m_write_n), 32'd1);
    chk("rwait_wd", m_writedata, 32'd0);
    chk("rwait_addr", 32'(m_address), 32'd0);
    csr_rd(2'd1, rd);
    chk("rwait_period", rd, 32'd0);
    tick();
    reset_n = 1'b1;
    clr_mon();
    repeat (40) tick();
    chk("rwait_no_restart", 32'(q_data.size()), 32'd0);
    csr_rd(2'd3, rd);
    chk("rwait_status", rd, 32'd0);

    chk("bus_data_stable", 32'(unstable), 32'd0);
    chk("bus_addr_zero", 32'(addr_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
